// File: rtl/seq_div_16bit.sv
// Iterative restoring divider: one quotient bit per clock, WIDTH iterations.
// Define SEQ_DIV_SIGNED_EN for two's-complement operands (sign-magnitude wrap around the unsigned core).
module seq_div_16bit #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned     CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [WIDTH:0]   p_q, p_d;
  logic [WIDTH-1:0] q_q, q_d, d_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q, done_q, dbz_q;
  logic [WIDTH-1:0] quo_q, rem_q;

  logic [WIDTH:0]   trial_a, trial_b, trial_g, trial_p, trial_t;
  logic [WIDTH+1:0] carry;
  logic             borrow;
  logic [WIDTH-1:0] dvd_mag, dvs_mag, quo_fin, rem_fin;

`ifdef SEQ_DIV_SIGNED_EN
  logic neg_quo_q, neg_rem_q;
`endif

  // Trial subtract a + ~b + 1 built from explicit generate/propagate terms
  always_comb begin
    trial_a  = {p_q[WIDTH-1:0], q_q[WIDTH-1]};
    trial_b  = ~{1'b0, d_q};
    trial_g  = trial_a & trial_b;
    trial_p  = trial_a ^ trial_b;
    carry    = '0;
    carry[0] = 1'b1;
    for (int unsigned i = 0; i <= WIDTH; i++) begin
      carry[i+1] = trial_g[i] | (trial_p[i] & carry[i]);
    end
    trial_t = trial_p ^ carry[WIDTH:0];
    borrow  = trial_t[WIDTH];
    p_d     = borrow ? trial_a : trial_t;
    q_d     = {q_q[WIDTH-2:0], ~borrow};
  end

  always_comb begin
`ifdef SEQ_DIV_SIGNED_EN
    dvd_mag = dividend[WIDTH-1] ? (~dividend + ONE) : dividend;
    dvs_mag = divisor[WIDTH-1]  ? (~divisor + ONE)  : divisor;
    quo_fin = neg_quo_q ? (~q_d + ONE) : q_d;
    rem_fin = neg_rem_q ? (~p_d[WIDTH-1:0] + ONE) : p_d[WIDTH-1:0];
`else
    dvd_mag = dividend;
    dvs_mag = divisor;
    quo_fin = q_d;
    rem_fin = p_d[WIDTH-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      p_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
`ifdef SEQ_DIV_SIGNED_EN
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            p_q   <= '0;
            q_q   <= dvd_mag;
            d_q   <= dvs_mag;
            cnt_q <= '0;
`ifdef SEQ_DIV_SIGNED_EN
            neg_quo_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_rem_q <= dividend[WIDTH-1];
`endif
            if (divisor == '0) begin
              // Zero divisor skips RUN entirely and reports from here
              state_q <= DONE;
              done_q  <= 1'b1;
              dbz_q   <= 1'b1;
              quo_q   <= '1;
              rem_q   <= dividend;
            end else begin
              state_q <= RUN;
              busy_q  <= 1'b1;
              dbz_q   <= 1'b0;
            end
          end
        end
        RUN: begin
          p_q   <= p_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            quo_q   <= quo_fin;
            rem_q   <= rem_fin;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule
